// File: rtl/apb_rr_master_arbiter_if.sv
// Bundle between the requester clients, the arbiter and the APB slave fabric.
// The master modport is the arbiter's view. The slave modport is the
// environment's view: the requesters plus the APB slaves.
interface apb_rr_master_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLV_NUM    = 15
);
  // requester side
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]                 req_write;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]              rsp_rdata;
  logic                               rsp_slverr;
  // APB side
  logic [ADDR_WIDTH-1:0]              paddr;
  logic [SLV_NUM-1:0]                 psel;
  logic                               penable;
  logic                               pwrite;
  logic [DATA_WIDTH-1:0]              pwdata;
  logic                               pready;
  logic [DATA_WIDTH-1:0]              prdata;
  logic                               pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, pready, prdata, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_slverr,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, pready, prdata, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_slverr,
           paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter that shares one APB master port between NUM_REQ
// requesters. It runs one transfer at a time through SETUP/ACCESS, decodes
// paddr to a one-hot psel, and returns the completion to the granted requester.
// The design does not synchronize presetn. Deassertion of presetn must already
// be aligned to pclk.
module apb_rr_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SLV_NUM        = 15,
  parameter int SLV_ADDR_LSB   = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   pclk,
  input  logic                   presetn,
  apb_rr_master_arbiter_if.master bus
);

  localparam int IDX_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DECERR,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  slverr_q, slverr_d;
  logic [TO_W-1:0]       tcnt_q, tcnt_d;

  logic [PTR_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic [IDX_W-1:0]      req_idx;
  logic                  bus_act;

  // Round-robin pick. The scan runs from the farthest slot back to the
  // nearest one, so the first valid at or after ptr is the last to assign.
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (bus.req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
  end

  assign req_idx = bus.req_addr[gnt_idx][SLV_ADDR_LSB +: IDX_W];

  // State and transfer registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      tcnt_q   <= tcnt_d;
    end
  end

  // Next-state logic: grant in IDLE, APB phase sequencing, and completion capture
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    tcnt_d   = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          gnt_d    = gnt_idx;
          ptr_d    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          addr_d   = bus.req_addr[gnt_idx];
          write_d  = bus.req_write[gnt_idx];
          wdata_d  = bus.req_wdata[gnt_idx];
          idx_d    = req_idx;
          rdata_d  = '0;
          slverr_d = 1'b0;
          tcnt_d   = '0;
          state_d  = (int'(req_idx) >= SLV_NUM) ? S_DECERR : S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (bus.pready) begin
          // Read data is returned only when a read completes cleanly.
          slverr_d = bus.pslverr;
          rdata_d  = (!write_q && !bus.pslverr) ? bus.prdata : '0;
          state_d  = S_RESP;
        end else if (TIMEOUT_CYCLES != 0 && tcnt_q == TO_LAST) begin
          slverr_d = 1'b1;
          rdata_d  = '0;
          state_d  = S_RESP;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      S_DECERR: begin
        slverr_d = 1'b1;
        rdata_d  = '0;
        state_d  = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_act = (state_q == S_SETUP) || (state_q == S_ACCESS);

  // APB drive and response data. All of these are 0 outside an active transfer.
  always_comb begin
    bus.psel       = bus_act ? (SLV_NUM'(1) << idx_q) : '0;
    bus.penable    = (state_q == S_ACCESS);
    bus.paddr      = bus_act ? addr_q : '0;
    bus.pwrite     = bus_act && write_q;
    bus.pwdata     = (bus_act && write_q) ? wdata_q : '0;
    bus.rsp_rdata  = (state_q == S_RESP) ? rdata_q : '0;
    bus.rsp_slverr = (state_q == S_RESP) && slverr_q;
  end

  // One ready and one response strobe per requester lane. The ready strobe is
  // gated by presetn so that it stays low while reset is held.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign bus.req_ready[i] = presetn && (state_q == S_IDLE) && gnt_any &&
                              (gnt_idx == PTR_W'(i));
    assign bus.rsp_valid[i] = (state_q == S_RESP) && (gnt_q == PTR_W'(i));
  end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Scoreboard bench for apb_rr_master_arbiter. A reference model predicts each
// grant from the round-robin rule and pushes the expected response. A monitor
// compares grants, APB drive and responses at negedge. An APB slave model
// derives its wait states and errors from the address.
module tb_apb_rr_master_arbiter;
  localparam int NR = 4;
  localparam int SN = 15;
  localparam int TO = 8;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_rr_master_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_NUM(SN)) bus();

  apb_rr_master_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_NUM(SN),
    .SLV_ADDR_LSB(12), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn), .bus(bus)
  );

  typedef struct {
    int          req;
    int          rcyc;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic        decerr;
    logic [31:0] rdata;
    logic        slverr;
  } exp_t;

  exp_t        q[$];
  int          glog[$];
  int          gcyc[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_chk = 0;
  int          ptr_m = 0;
  int          free_cyc = 0;
  int          w_ovr = -1;
  logic [31:0] slv_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] mem_dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] rd_slv(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : mem_dflt(a);
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_dflt(a);
  endfunction

  // Slave wait states: addr[6] means the slave never answers, otherwise addr[5:4]
  function automatic int wait_of(input logic [31:0] a);
    if (w_ovr >= 0) return w_ovr;
    if (a[6]) return 99;
    return int'(a[5:4]);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [3:0] idx;
    idx = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    return {16'h0, idx, 5'b0, ($urandom_range(0, 7) == 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
  endfunction

  // APB slave. It samples at negedge and drives 1 time unit after posedge.
  // Slave 7 always answers with pslverr.
  initial begin
    int          acc;
    logic        prev_pen;
    logic [31:0] a;
    acc = 0; prev_pen = 1'b0;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
    forever begin
      @(negedge pclk);
      if (presetn && bus.psel != '0 && bus.penable && bus.pready && bus.pwrite && !bus.pslverr)
        slv_mem[bus.paddr] = bus.pwdata;
      prev_pen = bus.penable;
      @(posedge pclk); #1;
      if (bus.psel != '0 && bus.penable) begin
        acc = prev_pen ? acc + 1 : 0;
        a = bus.paddr;
        bus.pready  = (acc == wait_of(a));
        bus.pslverr = bus.pready && (a[15:12] == 4'd7);
        bus.prdata  = !bus.pready ? '0 : (a[15:12] == 4'd7) ? 32'hBAD0_BAD0 : rd_slv(a);
      end else begin
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
      end
    end
  end

  // Reference model and monitor
  initial begin
    exp_t e;
    int   g;
    int   w;
    forever begin
      @(negedge pclk);
      if (!presetn) continue;
      // response
      while (q.size() > 0 && q[0].rcyc < cyc) begin
        chk("rsp_missing_cycle", cyc, q[0].rcyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && cyc == q[0].rcyc) begin
        chk("rsp_valid", bus.rsp_valid, 64'(1) << q[0].req);
        chk("rsp_rdata", bus.rsp_rdata, q[0].rdata);
        chk("rsp_slverr", bus.rsp_slverr, q[0].slverr);
        void'(q.pop_front());
      end else begin
        chk("rsp_valid_idle", bus.rsp_valid, 0);
        chk("rsp_rdata_idle", bus.rsp_rdata, 0);
        chk("rsp_slverr_idle", bus.rsp_slverr, 0);
      end
      // APB drive
      if (bus.psel != '0) begin
        if (q.size() == 0) chk("psel_unexpected", bus.psel, 0);
        else begin
          chk("psel", bus.psel, q[0].decerr ? 64'd0 : (64'(1) << q[0].addr[15:12]));
          chk("paddr", bus.paddr, q[0].addr);
          chk("pwrite", bus.pwrite, q[0].wr);
          chk("pwdata", bus.pwdata, q[0].wr ? q[0].wd : 32'd0);
        end
      end else begin
        chk("penable_idle", bus.penable, 0);
        chk("paddr_idle", bus.paddr, 0);
      end
      // grant
      if (cyc >= free_cyc && bus.req_valid != '0) begin
        g = -1;
        for (int k = 0; k < NR; k++)
          if (g < 0 && bus.req_valid[(ptr_m + k) % NR]) g = (ptr_m + k) % NR;
        chk("req_ready", bus.req_ready, 64'(1) << g);
        e.req = g; e.addr = bus.req_addr[g]; e.wr = bus.req_write[g]; e.wd = bus.req_wdata[g];
        e.decerr = 1'b0; e.rdata = '0; e.slverr = 1'b0;
        if (int'(e.addr[15:12]) >= SN) begin
          e.decerr = 1'b1; e.slverr = 1'b1; e.rcyc = cyc + 2;
        end else begin
          w = wait_of(e.addr);
          if (w >= TO) begin
            e.slverr = 1'b1; e.rcyc = cyc + 2 + TO;
          end else begin
            e.rcyc = cyc + 3 + w;
            e.slverr = (e.addr[15:12] == 4'd7);
            if (!e.wr && !e.slverr) e.rdata = rd_ref(e.addr);
            if (e.wr && !e.slverr) ref_mem[e.addr] = e.wd;
          end
        end
        q.push_back(e);
        ptr_m = (g + 1) % NR;
        free_cyc = e.rcyc + 1;
        glog.push_back(g);
        gcyc.push_back(cyc);
      end else if (bus.req_valid != '0 || bus.req_ready != '0) begin
        chk("req_ready_busy", bus.req_ready, 0);
      end
    end
  end

  // One request. It starts and ends 1 time unit after posedge.
  task automatic drive_req(input int i, input logic [31:0] a, input logic wr, input logic [31:0] wd);
    int n;
    bit got;
    n = 0; got = 1'b0;
    bus.req_addr[i] = a; bus.req_write[i] = wr; bus.req_wdata[i] = wd;
    bus.req_valid[i] = 1'b1;
    while (!got && n < 300) begin
      @(negedge pclk);
      if (bus.req_ready[i]) got = 1'b1;
      n++;
      @(posedge pclk); #1;
    end
    bus.req_valid[i] = 1'b0;
    if (!got) chk("grant_timeout", 0, 1);
  endtask

  task automatic rr_drv(input int i);
    repeat (2) drive_req(i, 32'(i) << 12, 1'b0, 32'h0);
  endtask

  task automatic rand_drv(input int i);
    repeat (15) begin
      repeat ($urandom_range(0, 4)) begin @(posedge pclk); #1; end
      drive_req(i, rand_addr(), 1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || cyc < free_cyc) && n < 100) begin @(posedge pclk); #1; n++; end
    if (n >= 100) chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int n;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    // reset state, with requests pending
    repeat (2) @(posedge pclk); #1;
    bus.req_valid = '1;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    bus.req_valid = '0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;

    // all four requesters valid back to back, ptr starts at 0
    w_ovr = 0; glog.delete(); gcyc.delete();
    fork rr_drv(0); rr_drv(1); rr_drv(2); rr_drv(3); join
    drain();
    if (glog.size() < 5) chk("rr_grant_count", glog.size(), 8);
    else for (int k = 0; k < 5; k++) begin
      chk("rr_grant", glog[k], k % NR);
      if (k < 4) chk("rr_spacing", gcyc[k+1] - gcyc[k], 4);
    end

    // single read, zero wait states
    slv_mem[32'h2010] = 32'hDEAD_BEEF; ref_mem[32'h2010] = 32'hDEAD_BEEF;
    drive_req(0, 32'h0000_2010, 1'b0, 32'h0);
    drain();
    // write with 3 wait states, then read the value back
    w_ovr = 3;
    drive_req(1, 32'h0000_5000, 1'b1, 32'h1234);
    drain();
    w_ovr = 0;
    drive_req(2, 32'h0000_5000, 1'b0, 32'h0);
    drain();
    // decode error
    w_ovr = -1;
    drive_req(3, 32'h0000_F000, 1'b0, 32'h0);
    drain();
    // ACCESS timeout, followed by a normal read from another requester
    fork
      drive_req(0, 32'h0000_3040, 1'b1, 32'hCAFE);
      drive_req(1, 32'h0000_3000, 1'b0, 32'h0);
    join
    drain();

    // random traffic on all requesters
    fork rand_drv(0); rand_drv(1); rand_drv(2); rand_drv(3); join
    drain();

    // reset during ACCESS
    drive_req(1, 32'h0000_1040, 1'b0, 32'h0);
    n = 0;
    while (!bus.penable && n < 20) begin @(negedge pclk); n++; end
    if (!bus.penable) chk("wait_penable", bus.penable, 1);
    #2 presetn = 1'b0;
    q.delete(); ptr_m = 0; free_cyc = 0; glog.delete(); gcyc.delete();
    bus.req_addr[0] = 32'h0000_0000; bus.req_addr[2] = 32'h0000_2000;
    bus.req_valid = 4'b0101;
    #1;
    chk("midrst_psel", bus.psel, 0);
    chk("midrst_penable", bus.penable, 0);
    chk("midrst_req_ready", bus.req_ready, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    repeat (2) @(posedge pclk); #1;
    presetn = 1'b1;
    w_ovr = 0;
    fork
      drive_req(0, 32'h0000_0000, 1'b0, 32'h0);
      drive_req(2, 32'h0000_2000, 1'b0, 32'h0);
    join
    drain();
    if (glog.size() > 0) chk("post_rst_first_grant", glog[0], 0);
    else chk("post_rst_grant_count", glog.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
